// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer.
// Decode sees the main (head) register; the skid register absorbs one extra beat under backpressure.
module if_id_skid_reg #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   up_valid_i,
    output logic                   up_ready_o,
    input  logic [PC_WIDTH-1:0]    up_pc_i,
    input  logic [INSTR_WIDTH-1:0] up_instr_i,
    output logic                   dn_valid_o,
    input  logic                   dn_ready_i,
    output logic [PC_WIDTH-1:0]    dn_pc_o,
    output logic [INSTR_WIDTH-1:0] dn_instr_o,
    output logic [1:0]             occupancy_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PC_WIDTH-1:0]    main_pc;
    logic [INSTR_WIDTH-1:0] main_instr;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic                   up_xfer;
    logic                   dn_xfer;
    logic                   load_main_up;
    logic                   load_main_skid;
    logic                   load_skid;
    logic                   clear_main;

    // Handshake outputs depend only on registered state, so ready never combinationally follows dn_ready_i.
    assign up_ready_o  = (state_q != FULL);
    assign dn_valid_o  = (state_q != EMPTY);
    assign occupancy_o = {state_q == FULL, state_q == BUSY};
    assign dn_pc_o     = main_pc;
    assign dn_instr_o  = main_instr;

    assign up_xfer = up_valid_i & up_ready_o;
    assign dn_xfer = dn_valid_o & dn_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        if (flush_i) begin
            state_d    = EMPTY;
            clear_main = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (up_xfer) begin
                        state_d      = BUSY;
                        load_main_up = 1'b1;
                    end
                end
                BUSY: begin
                    if (up_xfer && dn_xfer) begin
                        load_main_up = 1'b1;
                    end else if (up_xfer) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (dn_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dn_xfer) begin
                        state_d        = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_main) begin
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
        end else if (load_main_up) begin
            main_pc    <= up_pc_i;
            main_instr <= up_instr_i;
        end else if (load_main_skid) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
        end
    end

    // Skid contents are only meaningful in FULL, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_pc    <= up_pc_i;
            skid_instr <= up_instr_i;
        end
    end

endmodule
